axil_ptgen_master: RTL

//  Parametrised AXI4-Lite pattern-generator master; successor to the fixed write/read-back test master.
//  On an INIT pulse it writes NUM_TXN words of a selectable pattern, reads them back, compares and reports DONE/ERROR.

---
 rtl/axil_ptgen_master.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axil_ptgen_master.sv
// axil_ptgen_master: AXI4-Lite pattern-generator master.
// An INIT_AXI_TXN rising edge starts a run. Each pass writes NUM_TXN words of the
// selected pattern, reads them all back and compares them. TXN_DONE, ERROR and
// ERR_COUNT report the result of the run.
// Ports:
//   ACLK, ARESET        clock, synchronous active-high reset
//   INIT_AXI_TXN        start request (rising edge)
//   MODE, SEED          pattern select and seed, latched when a run starts
//   TXN_DONE            run complete (level)
//   ERROR, ERR_COUNT    sticky fail flag, saturating error-event count
//   M_AXI_*             AXI4-Lite master channels AW, W, B, AR, R
// Optional build macro PTGEN_ERR_CAPTURE_EN adds ERR_ADDR, ERR_EXP and ERR_GOT,
// which hold the details of the first error event of a run.
module axil_ptgen_master #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           NUM_TXN    = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h4000_0000),
    parameter int unsigned           NUM_PASS   = 1
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      INIT_AXI_TXN,
    input  logic [1:0]                MODE,
    input  logic [DATA_WIDTH-1:0]     SEED,
    output logic                      TXN_DONE,
    output logic                      ERROR,
    output logic [7:0]                ERR_COUNT,
    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                M_AXI_AWPROT,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                M_AXI_ARPROT,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
`ifdef PTGEN_ERR_CAPTURE_EN
    ,
    output logic [ADDR_WIDTH-1:0]     ERR_ADDR,
    output logic [DATA_WIDTH-1:0]     ERR_EXP,
    output logic [DATA_WIDTH-1:0]     ERR_GOT
`endif
);

    localparam int unsigned STRB_W     = DATA_WIDTH / 8;
    localparam int unsigned BYTE_SHIFT = $clog2(STRB_W);
    localparam int unsigned SHIFT_W    = $clog2(DATA_WIDTH);
    localparam int unsigned IDX_W      = 8;
    localparam int unsigned PASS_W     = 4;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_TXN - 1);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_DONE
    } state_t;

    state_t              state;
    logic                init_q;
    logic [1:0]          mode_q;
    logic [DATA_WIDTH-1:0] seed_q;
    logic [IDX_W-1:0]    idx_q;
    logic [PASS_W-1:0]   pass_q;

    logic                  start_c;
    logic                  err_event_c;
    logic [DATA_WIDTH-1:0] exp_c;

    // Byte address of word idx, wrapping modulo 2^ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [IDX_W-1:0] idx);
        return BASE_ADDR + (ADDR_WIDTH'(idx) << BYTE_SHIFT);
    endfunction

    // Pattern word for (mode, seed, pass, idx); read-back expectations reuse it.
    function automatic logic [DATA_WIDTH-1:0] word_data(input logic [1:0]            mode,
                                                        input logic [DATA_WIDTH-1:0] seed,
                                                        input logic [PASS_W-1:0]     pass,
                                                        input logic [IDX_W-1:0]      idx);
        logic [DATA_WIDTH-1:0] s;
        logic [DATA_WIDTH-1:0] res;
        s = seed + DATA_WIDTH'(pass) + DATA_WIDTH'(idx);
        case (mode)
            2'd0:    res = s;
            2'd1:    res = DATA_WIDTH'(1) << s[SHIFT_W-1:0];
            2'd2:    res = DATA_WIDTH'(word_addr(idx));
            default: res = ~s;
        endcase
        return res;
    endfunction

    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WSTRB  = {STRB_W{1'b1}};

    // Only the error bit of BRESP/RRESP matters; OKAY and EXOKAY are both success.
    wire unused_resp = &{1'b0, M_AXI_BRESP[0], M_AXI_RRESP[0]};

    // Start detection and per-word error event.
    always_comb begin
        start_c     = 1'b0;
        err_event_c = 1'b0;
        exp_c       = word_data(mode_q, seed_q, pass_q, idx_q);
        if (INIT_AXI_TXN && !init_q && (state == S_IDLE || state == S_DONE))
            start_c = 1'b1;
        if (state == S_WR_RESP && M_AXI_BVALID && M_AXI_BREADY && M_AXI_BRESP[1])
            err_event_c = 1'b1;
        if (state == S_RD_DATA && M_AXI_RVALID && M_AXI_RREADY &&
            (M_AXI_RRESP[1] || (M_AXI_RDATA != exp_c)))
            err_event_c = 1'b1;
    end

    // Sequencer: write all words, read them all back, repeat per pass.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state         <= S_IDLE;
            init_q        <= 1'b0;
            mode_q        <= 2'd0;
            seed_q        <= '0;
            idx_q         <= '0;
            pass_q        <= '0;
            TXN_DONE      <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            init_q <= INIT_AXI_TXN;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_c) begin
                        mode_q        <= MODE;
                        seed_q        <= SEED;
                        idx_q         <= '0;
                        pass_q        <= '0;
                        TXN_DONE      <= 1'b0;
                        M_AXI_AWADDR  <= word_addr('0);
                        M_AXI_WDATA   <= word_data(MODE, SEED, '0, '0);
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                        state         <= S_WR_ADDR;
                    end
                end
                S_WR_ADDR: begin
                    // Each valid drops on its own handshake; a low valid here means already accepted.
                    if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
                    if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            idx_q         <= '0;
                            M_AXI_ARADDR  <= word_addr('0);
                            M_AXI_ARVALID <= 1'b1;
                            state         <= S_RD_ADDR;
                        end else begin
                            idx_q         <= idx_q + IDX_W'(1);
                            M_AXI_AWADDR  <= word_addr(idx_q + IDX_W'(1));
                            M_AXI_WDATA   <= word_data(mode_q, seed_q, pass_q, idx_q + IDX_W'(1));
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state         <= S_WR_ADDR;
                        end
                    end
                end
                S_RD_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        if (idx_q != LAST_IDX) begin
                            idx_q         <= idx_q + IDX_W'(1);
                            M_AXI_ARADDR  <= word_addr(idx_q + IDX_W'(1));
                            M_AXI_ARVALID <= 1'b1;
                            state         <= S_RD_ADDR;
                        end else if (pass_q != LAST_PASS) begin
                            idx_q         <= '0;
                            pass_q        <= pass_q + PASS_W'(1);
                            M_AXI_AWADDR  <= word_addr('0);
                            M_AXI_WDATA   <= word_data(mode_q, seed_q, pass_q + PASS_W'(1), '0);
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state         <= S_WR_ADDR;
                        end else begin
                            TXN_DONE <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef PTGEN_ERR_CAPTURE_EN
    logic [ADDR_WIDTH-1:0] cur_addr_c;
    logic [DATA_WIDTH-1:0] got_c;

    // Write-response errors have no read data to report.
    always_comb begin
        cur_addr_c = word_addr(idx_q);
        got_c      = (state == S_RD_DATA) ? M_AXI_RDATA : '0;
    end
`endif

    // Sticky error flag, saturating count and optional first-error capture.
    always_ff @(posedge ACLK) begin
        if (ARESET || start_c) begin
            ERROR     <= 1'b0;
            ERR_COUNT <= 8'd0;
`ifdef PTGEN_ERR_CAPTURE_EN
            ERR_ADDR  <= '0;
            ERR_EXP   <= '0;
            ERR_GOT   <= '0;
`endif
        end else if (err_event_c) begin
            ERROR <= 1'b1;
            if (ERR_COUNT != 8'hFF)
                ERR_COUNT <= ERR_COUNT + 8'd1;
`ifdef PTGEN_ERR_CAPTURE_EN
            if (!ERROR) begin
                ERR_ADDR <= cur_addr_c;
                ERR_EXP  <= exp_c;
                ERR_GOT  <= got_c;
            end
`endif
        end
    end

endmodule
